// File: rtl/crp16_alu_writeback_pkg.sv
// crp16_defs: shared definitions for the CRP16 ALU writeback stage.
//   - DATA_W/REG_W defaults
//   - branch condition codes COND_AL..COND_GE
//   - bit positions of the {V,C,N,Z} flag register
//   - occupancy states of the 2-entry skid buffer
package crp16_defs;
    localparam int DATA_W_DEF = 16;
    localparam int REG_W_DEF  = 3;

    localparam logic [2:0] COND_AL = 3'd0;  // always
    localparam logic [2:0] COND_EQ = 3'd1;  // Z
    localparam logic [2:0] COND_NE = 3'd2;  // !Z
    localparam logic [2:0] COND_CS = 3'd3;  // C
    localparam logic [2:0] COND_CC = 3'd4;  // !C
    localparam logic [2:0] COND_MI = 3'd5;  // N
    localparam logic [2:0] COND_LT = 3'd6;  // N^V
    localparam logic [2:0] COND_GE = 3'd7;  // !(N^V)

    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;
endpackage

// File: rtl/crp16_alu_writeback_if.sv
// crp16_alu_writeback_if: ALU-result and writeback handshake buses.
//   ALU side : in_valid/in_ready, in_data, in_v, in_c, in_reg, in_we, in_setf
//   RF side  : wb_valid/wb_ready, wb_data, wb_reg, wb_we
//   slave  = the writeback stage view, master = the ALU/register-file view.
interface crp16_alu_writeback_if #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_v;
    logic              in_c;
    logic [REG_W-1:0]  in_reg;
    logic              in_we;
    logic              in_setf;

    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_data;
    logic [REG_W-1:0]  wb_reg;
    logic              wb_we;

    modport slave (
        input  in_valid, in_data, in_v, in_c, in_reg, in_we, in_setf, wb_ready,
        output in_ready, wb_valid, wb_data, wb_reg, wb_we
    );

    modport master (
        output in_valid, in_data, in_v, in_c, in_reg, in_we, in_setf, wb_ready,
        input  in_ready, wb_valid, wb_data, wb_reg, wb_we
    );
endinterface

// File: rtl/crp16_skid_buffer.sv
// crp16_skid_buffer: generic 2-entry valid/ready buffer with a registered
// upstream ready. The main slot drives the output; the skid slot only
// catches the entry accepted while main is full and stalled.
//   clk_i, rst_i          clock, synchronous active-high reset
//   in_valid_i/in_ready_o  upstream handshake, in_data_i payload
//   out_valid_o/out_ready_i downstream handshake, out_data_o payload
//   main_*/skid_*          slot contents, exposed for forwarding
module crp16_skid_buffer
    import crp16_defs::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic         main_valid_o,
    output logic [W-1:0] main_data_o,
    output logic         skid_valid_o,
    output logic [W-1:0] skid_data_o
);
    occ_e         state_q, state_d;
    logic         rdy_q;
    logic [W-1:0] main_q, skid_q;
    logic         accept, present;

    assign accept  = in_valid_i & rdy_q;
    assign present = (state_q != OCC_EMPTY) & out_ready_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            OCC_EMPTY: if (accept) state_d = OCC_ONE;
            OCC_ONE: begin
                if (accept && !present)      state_d = OCC_TWO;
                else if (!accept && present) state_d = OCC_EMPTY;
            end
            // No accept is possible here: rdy_q is low whenever we sit in TWO.
            OCC_TWO:   if (present) state_d = OCC_ONE;
            default:   state_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= OCC_EMPTY;
            rdy_q   <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            // Ready depends only on next occupancy, so it is a clean flop.
            rdy_q   <= (state_d != OCC_TWO);
            if (present && state_q == OCC_TWO)
                main_q <= skid_q;
            else if (accept && (state_q == OCC_EMPTY || present))
                main_q <= in_data_i;
            else if (accept)
                skid_q <= in_data_i;
        end
    end

    assign in_ready_o   = rdy_q;
    assign out_valid_o  = (state_q != OCC_EMPTY);
    assign out_data_o   = main_q;
    assign main_valid_o = (state_q != OCC_EMPTY);
    assign main_data_o  = main_q;
    assign skid_valid_o = (state_q == OCC_TWO);
    assign skid_data_o  = skid_q;
endmodule

// File: rtl/crp16_alu_writeback.sv
// crp16_alu_writeback: execute-to-writeback stage behind the CRP16 ALU.
// Buffers {we, reg, data} through a 2-entry skid buffer towards the register
// file, holds the architectural {V,C,N,Z} flags and evaluates branch
// conditions against them.
//   clock, reset        sole clock, synchronous active-high reset
//   bus (slave)         ALU-result and writeback handshakes
//   flags               {V,C,N,Z}
//   cond / cond_true    condition code and its evaluation on current flags
//   rd_a/rd_b, fwd_*    forwarding view; live only with CRP16_WB_FORWARD_EN,
//                       otherwise fwd_* read as zero and rd_* are ignored
module crp16_alu_writeback
    import crp16_defs::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    crp16_alu_writeback_if.slave bus,
    output logic [3:0]          flags,
    input  logic [2:0]          cond,
    output logic                cond_true,
    input  logic [REG_W-1:0]    rd_a,
    input  logic [REG_W-1:0]    rd_b,
    output logic                fwd_hit_a,
    output logic                fwd_hit_b,
    output logic [DATA_W-1:0]   fwd_data_a,
    output logic [DATA_W-1:0]   fwd_data_b
);
    localparam int PW = 1 + REG_W + DATA_W;

    logic [PW-1:0] in_pay, out_pay, main_pay, skid_pay;
    logic          main_v, skid_v;
    logic [3:0]    flags_q, flags_d;
    logic          accept;

    assign in_pay = {bus.in_we, bus.in_reg, bus.in_data};

    crp16_skid_buffer #(.W(PW)) u_skid (
        .clk_i        (clock),
        .rst_i        (reset),
        .in_valid_i   (bus.in_valid),
        .in_ready_o   (bus.in_ready),
        .in_data_i    (in_pay),
        .out_valid_o  (bus.wb_valid),
        .out_ready_i  (bus.wb_ready),
        .out_data_o   (out_pay),
        .main_valid_o (main_v),
        .main_data_o  (main_pay),
        .skid_valid_o (skid_v),
        .skid_data_o  (skid_pay)
    );

    assign {bus.wb_we, bus.wb_reg, bus.wb_data} = out_pay;

    // Flags follow every accepted result with setf, regardless of whether
    // the register file is stalling. Z is derived from the data here.
    assign accept = bus.in_valid & bus.in_ready;

    always_comb begin
        flags_d = flags_q;
        if (accept && bus.in_setf) begin
            flags_d[FLAG_V] = bus.in_v;
            flags_d[FLAG_C] = bus.in_c;
            flags_d[FLAG_N] = bus.in_data[DATA_W-1];
            flags_d[FLAG_Z] = (bus.in_data == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) flags_q <= 4'b0000;
        else       flags_q <= flags_d;
    end

    assign flags = flags_q;

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_AL: cond_true = 1'b1;
            COND_EQ: cond_true = flags_q[FLAG_Z];
            COND_NE: cond_true = ~flags_q[FLAG_Z];
            COND_CS: cond_true = flags_q[FLAG_C];
            COND_CC: cond_true = ~flags_q[FLAG_C];
            COND_MI: cond_true = flags_q[FLAG_N];
            COND_LT: cond_true = flags_q[FLAG_N] ^ flags_q[FLAG_V];
            COND_GE: cond_true = ~(flags_q[FLAG_N] ^ flags_q[FLAG_V]);
            default: cond_true = 1'b0;
        endcase
    end

`ifdef CRP16_WB_FORWARD_EN
    // Skid holds the younger entry, so it wins over main on a double match.
    logic m_a, m_b, s_a, s_b;
    assign m_a = main_v & main_pay[PW-1] & (main_pay[DATA_W +: REG_W] == rd_a);
    assign m_b = main_v & main_pay[PW-1] & (main_pay[DATA_W +: REG_W] == rd_b);
    assign s_a = skid_v & skid_pay[PW-1] & (skid_pay[DATA_W +: REG_W] == rd_a);
    assign s_b = skid_v & skid_pay[PW-1] & (skid_pay[DATA_W +: REG_W] == rd_b);

    assign fwd_hit_a  = m_a | s_a;
    assign fwd_hit_b  = m_b | s_b;
    assign fwd_data_a = s_a ? skid_pay[DATA_W-1:0] :
                        m_a ? main_pay[DATA_W-1:0] : '0;
    assign fwd_data_b = s_b ? skid_pay[DATA_W-1:0] :
                        m_b ? main_pay[DATA_W-1:0] : '0;
`else
    logic unused_fwd;
    assign unused_fwd = ^{rd_a, rd_b, main_v, main_pay, skid_v, skid_pay};
    assign fwd_hit_a  = 1'b0;
    assign fwd_hit_b  = 1'b0;
    assign fwd_data_a = '0;
    assign fwd_data_b = '0;
`endif
endmodule

// File: doc/crp16_alu_writeback.md
Name: crp16_alu_writeback

Overview:
- Execute-to-writeback stage directly downstream of the CRP16 ALU.
- Captures each ALU result with its destination register tag and flag outputs.
- Holds the architectural VCNZ flag register and evaluates branch conditions against it.
- Presents results to the register file through a 2-entry skid buffer with valid/ready handshakes, so the ALU-side ready is a registered signal and the stage sustains full throughput.

Parameters:
- DATA_W, 16, datapath width; flag N is bit DATA_W-1.
- REG_W, 3, destination register index width (8 GPRs).

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  ALU result valid this cycle
- in_ready  out  1  stage can accept; registered
- in_data  in  DATA_W  ALU result
- in_v  in  1  ALU overflow flag
- in_c  in  1  ALU carry-out flag
- in_reg  in  REG_W  destination register index
- in_we  in  1  result is written to the register file
- in_setf  in  1  result updates the flag register
- wb_valid  out  1  writeback entry valid
- wb_ready  in  1  register file accepts the entry
- wb_data  out  DATA_W  writeback data
- wb_reg  out  REG_W  writeback register index
- wb_we  out  1  register write enable qualifier
- flags  out  4  architectural flags {V,C,N,Z}
- cond  in  3  branch condition code
- cond_true  out  1  condition holds on the current flags

Behaviour:
- Reset values: in_ready=1; wb_valid=0; wb_data=0; wb_reg=0; wb_we=0; flags=4'b0000; both buffer slots empty.
- Accept when in_valid & in_ready. Present when wb_valid & wb_ready.
- Structure: main slot drives wb_*; skid slot is the overflow.
  - Accept, main empty or draining this cycle: entry goes to main.
  - Accept, main full and stalled: entry goes to skid.
  - Present with skid full: skid moves to main.
  - in_ready next cycle = skid slot empty.
- Latency: accept at edge k, wb_valid=1 after edge k (1 cycle).
- Throughput: 1 entry/cycle while wb_ready=1.
- Ordering is strictly FIFO.
- Simultaneous accept and present with both slots full cannot occur, because in_ready=0 in that state.
- Occupancy states:
  - EMPTY: accept → ONE.
  - ONE: accept without present → TWO; present without accept → EMPTY; both → ONE, with main replaced.
  - TWO: present → ONE. No accept is possible.
- Flags update on the accept edge when in_setf=1; otherwise they hold.
  - V=in_v, C=in_c.
  - N=in_data[DATA_W-1].
  - Z=(in_data==0). Z is recomputed here from the data; no upstream zero flag is used.
  - The update is independent of buffer occupancy and of wb_ready.
- in_we=0 entries still pass through the buffer with wb_we=0, which keeps ordering intact.
- cond_true is combinational from the flags register (never from in_*):
  - 0 always; 1 Z; 2 !Z; 3 C; 4 !C; 5 N; 6 N^V (lt); 7 !(N^V) (ge).
- Reset asserted mid-operation: both slots are discarded with no writeback, and flags clear, on that edge.
- Outputs wb_* are don't-care while wb_valid=0 but are held stable, with no X.

Optional Feature:
- CRP16_WB_FORWARD_EN: adds a forwarding view for the upstream operand muxes.
  - Ports fwd_hit_a/fwd_hit_b (out, 1), fwd_data_a/fwd_data_b (out, DATA_W), and operand indices rd_a/rd_b (in, REG_W).
  - Priority: youngest valid entry with wb_we=1 and a matching index wins (skid over main).
- Without the macro the ports still exist. fwd_hit_* are tied to 0 and fwd_data_* to 0, and the rd_* inputs are ignored.

Decomposition:
- Shared package crp16_defs:
  - Condition-code constants COND_AL..COND_GE.
  - Flag bit positions FLAG_V=3, FLAG_C=2, FLAG_N=1, FLAG_Z=0.
  - The DATA_W/REG_W defaults.
- One natural sub-module: crp16_skid_buffer, a generic width-parameterised 2-entry valid/ready buffer. It is instantiated once with payload {we, reg, data}.
- Flag register and condition logic stay in the top module.

Test Plan:
- Reset, then check idle outputs → in_ready=1, wb_valid=0, flags=0, and cond=0 gives cond_true=1 while cond=1 gives cond_true=0.
- Back-to-back results 0x0001, 0x0002, 0x0003 to r1..r3 with wb_ready=1 → each appears one cycle later in order, and in_ready stays 1.
- Hold wb_ready=0 while sending 0x1111 and 0x2222 → in_ready drops after the second accept. Then set wb_ready=1 → 0x1111 then 0x2222 emerge on consecutive cycles and in_ready returns to 1.
- Flag updates:
  - Data 0x0000 with setf=1 → Z=1, cond 1 true.
  - Data 0x8000 with v=1, setf=1 → N=1, V=1, cond 6 false, cond 7 true.
  - Data 0x1234 with setf=0 → flags unchanged.
- With two entries buffered, assert reset → next cycle wb_valid=0, in_ready=1, flags=0, and nothing is written afterwards.
- With CRP16_WB_FORWARD_EN and both slots writing r5 (main 0xAAAA, skid 0xBBBB), rd_a=5 → fwd_hit_a=1 and fwd_data_a=0xBBBB. Without the macro → fwd_hit_a=0.
